// File: rtl/ct_had_ser_pkg.sv
// Shared definitions for the HAD serial command engine: state encoding and field widths.
// Optional build macro HAD_SER_PARITY_EN adds odd-parity slots (see ct_had_serial_sm).
package ct_had_ser_pkg;

    localparam int HACR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 64;
    localparam int CNT_W_DEF   = 7;
    localparam int HACR_RW_BIT = 15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HACR     = 3'd1,
        S_UPD_H    = 3'd2,
        S_DECODE   = 3'd3,
        S_CAPTURE  = 3'd4,
        S_RD_SHIFT = 3'd5,
        S_WR_SHIFT = 3'd6,
        S_WR_UPD   = 3'd7
    } sm_state_e;

endpackage

// File: rtl/ct_had_ser_shreg.sv
// Data shift register for the HAD serial engine: parallel load, MSB shift-in (which is
// also the LSB shift-out path), HACR-field shift-in, and the frame bit counter.
module ct_had_ser_shreg #(
    parameter int HACR_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 7
) (
    input  logic              ir_clk,
    input  logic              cpurst_b,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_hacr,
    input  logic              shift_msb,
    input  logic              shift_in,
    input  logic              cnt_clr,
    input  logic              cnt_inc,
    output logic [DATA_W-1:0] data,
    output logic              lsb,
    output logic [CNT_W-1:0]  cnt,
    output logic              last_hacr,
    output logic              last_data
);

    logic [DATA_W-1:0] shreg;

    // NOTE: the shift register is reset explicitly because it drives serial_xx_data directly.
    always_ff @(posedge ir_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (clr)
                shreg <= '0;
            else if (load)
                shreg <= load_data;
            else if (shift_hacr)
                shreg[HACR_W-1:0] <= {shift_in, shreg[HACR_W-1:1]};
            else if (shift_msb)
                shreg <= {shift_in, shreg[DATA_W-1:1]};

            if (clr || cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign data      = shreg;
    assign lsb       = shreg[0];
    assign last_hacr = (cnt == CNT_W'(HACR_W - 1));
    assign last_data = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/ct_had_serial_sm.sv
// HAD serial command engine: shifts in a HACR command, then reads out or writes a data word.
// Define HAD_SER_PARITY_EN to add odd-parity slots after the HACR, write and read fields.
module ct_had_serial_sm
    import ct_had_ser_pkg::*;
#(
    parameter int HACR_W = HACR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              ir_clk,
    input  logic              cpurst_b,
    input  logic              ser_vld,
    input  logic              ser_bit,
    input  logic              had_abort,
    input  logic              ir_sm_hacr_rw,
    input  logic [DATA_W-1:0] regs_serial_data,
    output logic              sm_ir_update_hacr,
    output logic [DATA_W-1:0] serial_xx_data,
    output logic              sm_regs_wr,
    output logic              ser_out_bit,
    output logic              ser_out_vld,
    output logic              sm_busy,
    output logic              sm_frame_err
);

    sm_state_e         state;
    logic              upd_q, wr_q;
    logic              clr, load, shift_hacr, shift_msb, sh_in, cnt_clr, cnt_inc;
    logic              lsb, last_hacr, last_data;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;

`ifdef HAD_SER_PARITY_EN
    localparam logic [CNT_W-1:0] CNT_HACR_PAR = CNT_W'(HACR_W);
    localparam logic [CNT_W-1:0] CNT_DATA_PAR = CNT_W'(DATA_W);
    logic par_q;
    logic hacr_par_slot, data_par_slot;
    assign hacr_par_slot = (cnt == CNT_HACR_PAR);
    assign data_par_slot = (cnt == CNT_DATA_PAR);
`endif

    ct_had_ser_shreg #(
        .HACR_W(HACR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .ir_clk    (ir_clk),
        .cpurst_b  (cpurst_b),
        .clr       (clr),
        .load      (load),
        .load_data (regs_serial_data),
        .shift_hacr(shift_hacr),
        .shift_msb (shift_msb),
        .shift_in  (sh_in),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .data      (data),
        .lsb       (lsb),
        .cnt       (cnt),
        .last_hacr (last_hacr),
        .last_data (last_data)
    );

    // NOTE: every control gets a default first so this block can never infer a latch.
    always_comb begin
        clr        = 1'b0;
        load       = 1'b0;
        shift_hacr = 1'b0;
        shift_msb  = 1'b0;
        sh_in      = ser_bit;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (had_abort) begin
            clr = 1'b1;
        end else begin
            case (state)
                S_IDLE:     clr = ser_vld && ser_bit;
                S_HACR: if (ser_vld) begin
`ifdef HAD_SER_PARITY_EN
                    if (!hacr_par_slot) begin
                        shift_hacr = 1'b1;
                        cnt_inc    = 1'b1;
                    end
`else
                    shift_hacr = 1'b1;
                    cnt_inc    = 1'b1;
`endif
                end
                S_DECODE:   clr = !ir_sm_hacr_rw;
                S_CAPTURE: begin
                    load    = 1'b1;
                    cnt_clr = 1'b1;
                end
                S_RD_SHIFT: if (ser_vld) begin
                    shift_msb = 1'b1;
                    sh_in     = 1'b0;
                    cnt_inc   = 1'b1;
                end
                S_WR_SHIFT: if (ser_vld) begin
`ifdef HAD_SER_PARITY_EN
                    if (!data_par_slot) begin
                        shift_msb = 1'b1;
                        cnt_inc   = 1'b1;
                    end
`else
                    shift_msb = 1'b1;
                    cnt_inc   = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge ir_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state        <= S_IDLE;
            upd_q        <= 1'b0;
            wr_q         <= 1'b0;
            ser_out_vld  <= 1'b0;
            sm_busy      <= 1'b0;
            sm_frame_err <= 1'b0;
`ifdef HAD_SER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            upd_q <= 1'b0;
            wr_q  <= 1'b0;
            if (had_abort) begin
                state       <= S_IDLE;
                ser_out_vld <= 1'b0;
                sm_busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (ser_vld && ser_bit) begin
                        state        <= S_HACR;
                        sm_frame_err <= 1'b0;
                    end
                    S_HACR: if (ser_vld) begin
`ifdef HAD_SER_PARITY_EN
                        if (hacr_par_slot) begin
                            if (ser_bit == ~^data[HACR_W-1:0]) begin
                                state   <= S_UPD_H;
                                upd_q   <= 1'b1;
                                sm_busy <= 1'b1;
                            end else begin
                                state        <= S_IDLE;
                                sm_frame_err <= 1'b1;
                            end
                        end
`else
                        if (last_hacr) begin
                            state   <= S_UPD_H;
                            upd_q   <= 1'b1;
                            sm_busy <= 1'b1;
                        end
`endif
                    end
                    S_UPD_H: begin
                        state <= S_DECODE;
                        if (ser_vld) sm_frame_err <= 1'b1;
                    end
                    S_DECODE: begin
                        if (ir_sm_hacr_rw) begin
                            state <= S_CAPTURE;
                        end else begin
                            state   <= S_WR_SHIFT;
                            sm_busy <= 1'b0;
                        end
                        if (ser_vld) sm_frame_err <= 1'b1;
                    end
                    S_CAPTURE: begin
                        state       <= S_RD_SHIFT;
                        sm_busy     <= 1'b0;
                        ser_out_vld <= 1'b1;
`ifdef HAD_SER_PARITY_EN
                        par_q       <= ~^regs_serial_data;
`endif
                        if (ser_vld) sm_frame_err <= 1'b1;
                    end
                    S_RD_SHIFT: begin
`ifdef HAD_SER_PARITY_EN
                        if (ser_vld && data_par_slot) begin
`else
                        if (ser_vld && last_data) begin
`endif
                            state       <= S_IDLE;
                            ser_out_vld <= 1'b0;
                        end
                    end
                    S_WR_SHIFT: if (ser_vld) begin
`ifdef HAD_SER_PARITY_EN
                        if (data_par_slot) begin
                            if (ser_bit == ~^data) begin
                                state   <= S_WR_UPD;
                                wr_q    <= 1'b1;
                                sm_busy <= 1'b1;
                            end else begin
                                state        <= S_IDLE;
                                sm_frame_err <= 1'b1;
                            end
                        end
`else
                        if (last_data) begin
                            state   <= S_WR_UPD;
                            wr_q    <= 1'b1;
                            sm_busy <= 1'b1;
                        end
`endif
                    end
                    S_WR_UPD: begin
                        state   <= S_IDLE;
                        sm_busy <= 1'b0;
                        if (ser_vld) sm_frame_err <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Strobes are gated so an abort in UPD_H or WR_UPD cancels the pulse in that same cycle.
    assign sm_ir_update_hacr = upd_q & ~had_abort;
    assign sm_regs_wr        = wr_q & ~had_abort;
    assign serial_xx_data    = data;
`ifdef HAD_SER_PARITY_EN
    assign ser_out_bit = ser_out_vld & (data_par_slot ? par_q : lsb);
`else
    assign ser_out_bit = ser_out_vld & lsb;
`endif

endmodule

// File: tb/tb_ct_had_serial_sm.sv
// Directed self-checking bench for ct_had_serial_sm (honours HAD_SER_PARITY_EN if defined).
module tb_ct_had_serial_sm;

    localparam logic [63:0] RD_WORD = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WR_WORD = 64'hDEAD_BEEF_0000_FFFF;
    localparam logic [63:0] WR_W2   = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] WR_W3   = 64'h8000_0000_0000_0001;

    logic        ir_clk = 1'b0;
    logic        cpurst_b = 1'b0;
    logic        ser_vld = 1'b0;
    logic        ser_bit = 1'b0;
    logic        had_abort = 1'b0;
    logic        ir_sm_hacr_rw = 1'b0;
    logic [63:0] regs_serial_data = '0;
    logic        sm_ir_update_hacr, sm_regs_wr, ser_out_bit, ser_out_vld, sm_busy, sm_frame_err;
    logic [63:0] serial_xx_data;

    int checks = 0;
    int passes = 0;
    int upd_cnt = 0;
    int wr_cnt = 0;
    int base;
    logic [63:0] rd;
    logic        vld_all;

    ct_had_serial_sm dut (
        .ir_clk           (ir_clk),
        .cpurst_b         (cpurst_b),
        .ser_vld          (ser_vld),
        .ser_bit          (ser_bit),
        .had_abort        (had_abort),
        .ir_sm_hacr_rw    (ir_sm_hacr_rw),
        .regs_serial_data (regs_serial_data),
        .sm_ir_update_hacr(sm_ir_update_hacr),
        .serial_xx_data   (serial_xx_data),
        .sm_regs_wr       (sm_regs_wr),
        .ser_out_bit      (ser_out_bit),
        .ser_out_vld      (ser_out_vld),
        .sm_busy          (sm_busy),
        .sm_frame_err     (sm_frame_err)
    );

    always #5 ir_clk = ~ir_clk;

    always @(negedge ir_clk) begin
        if (sm_ir_update_hacr) upd_cnt++;
        if (sm_regs_wr)        wr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ir_clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        ser_vld = 1'b1;
        ser_bit = b;
        tick();
        ser_vld = 1'b0;
        ser_bit = 1'b0;
    endtask

    task automatic send_hacr(input logic [15:0] h);
        strobe(1'b1);
        for (int i = 0; i < 16; i++) strobe(h[i]);
`ifdef HAD_SER_PARITY_EN
        strobe(~^h);
`endif
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 64; i++) strobe(w[i]);
`ifdef HAD_SER_PARITY_EN
        strobe(~^w);
`endif
    endtask

    // Full write frame; leaves the engine in WR_UPD with the strobe visible.
    task automatic write_frame(input logic [15:0] h, input logic [63:0] w);
        ir_sm_hacr_rw = 1'b0;
        send_hacr(h);
        tick();
        tick();
        send_word(w);
    endtask

    initial begin
        tick();
        tick();
        check("rst_upd",   sm_ir_update_hacr, 0);
        check("rst_data",  serial_xx_data, 0);
        check("rst_wr",    sm_regs_wr, 0);
        check("rst_obit",  ser_out_bit, 0);
        check("rst_ovld",  ser_out_vld, 0);
        check("rst_busy",  sm_busy, 0);
        check("rst_err",   sm_frame_err, 0);
        cpurst_b = 1'b1;
        tick();

        // Read frame, preceded by zero strobes that must not start a frame
        ir_sm_hacr_rw    = 1'b1;
        regs_serial_data = RD_WORD;
        base = upd_cnt;
        strobe(1'b0);
        strobe(1'b0);
        send_hacr(16'h8200);
        check("upd_pulse", sm_ir_update_hacr, 1);
        check("upd_hacr",  serial_xx_data[15:0], 16'h8200);
        check("upd_busy",  sm_busy, 1);
        tick();
        check("dec_upd_low", sm_ir_update_hacr, 0);
        tick();
        check("cap_ovld", ser_out_vld, 0);
        tick();
        check("rd_first_vld", ser_out_vld, 1);
        check("upd_once", upd_cnt - base, 1);
        vld_all = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd[i] = ser_out_bit;
            if (!ser_out_vld) vld_all = 1'b0;
            strobe(1'b1);
        end
`ifdef HAD_SER_PARITY_EN
        check("rd_parity", ser_out_bit, ~^RD_WORD);
        strobe(1'b1);
`endif
        check("rd_data",    rd, RD_WORD);
        check("rd_vld_all", vld_all, 1);
        check("rd_end_vld", ser_out_vld, 0);
        check("rd_end_busy", sm_busy, 0);

        // Write frame
        base = wr_cnt;
        write_frame(16'h0215, WR_WORD);
        check("wr_pulse", sm_regs_wr, 1);
        check("wr_data",  serial_xx_data, WR_WORD);
        check("wr_busy",  sm_busy, 1);
        tick();
        check("wr_once",  wr_cnt - base, 1);
        check("wr_idle_busy", sm_busy, 0);

        // Abort on the 10th write-data bit
        base = wr_cnt;
        ir_sm_hacr_rw = 1'b0;
        send_hacr(16'h0215);
        tick();
        tick();
        for (int i = 0; i < 9; i++) strobe(WR_W2[i]);
        had_abort = 1'b1;
        strobe(WR_W2[9]);
        had_abort = 1'b0;
        check("abort_data", serial_xx_data, 0);
        check("abort_busy", sm_busy, 0);
        repeat (3) tick();
        check("abort_no_wr", wr_cnt - base, 0);
        write_frame(16'h0215, WR_W2);
        check("post_abort_wr",   sm_regs_wr, 1);
        check("post_abort_data", serial_xx_data, WR_W2);
        tick();

        // Abort landing in WR_UPD cancels the write strobe
        base = wr_cnt;
        write_frame(16'h0215, WR_WORD);
        had_abort = 1'b1;
        #1;
        check("abort_wrupd_strobe", sm_regs_wr, 0);
        tick();
        had_abort = 1'b0;
        tick();
        check("abort_wrupd_cnt", wr_cnt - base, 0);

        // Strobe during DECODE is dropped and flags an error until the next start bit
        base = wr_cnt;
        ir_sm_hacr_rw = 1'b0;
        send_hacr(16'h0215);
        tick();
        strobe(1'b1);
        check("busy_err_set", sm_frame_err, 1);
        send_word(WR_W3);
        check("busy_drop_data", serial_xx_data, WR_W3);
        check("busy_drop_wr",   sm_regs_wr, 1);
        tick();
        check("err_sticky", sm_frame_err, 1);
        strobe(1'b1);
        check("err_cleared", sm_frame_err, 0);
        had_abort = 1'b1;
        tick();
        had_abort = 1'b0;

        // Asynchronous reset mid-frame
        write_frame(16'h0215, WR_WORD);
        #2;
        cpurst_b = 1'b0;
        #1;
        check("arst_data", serial_xx_data, 0);
        check("arst_busy", sm_busy, 0);
        check("arst_wr",   sm_regs_wr, 0);
        cpurst_b = 1'b1;
        tick();

`ifdef HAD_SER_PARITY_EN
        // Wrong HACR parity suppresses the update; the correct bit lets it through
        base = upd_cnt;
        ir_sm_hacr_rw = 1'b1;
        strobe(1'b1);
        for (int i = 0; i < 16; i++) strobe(rd[0] ^ rd[0] ^ ((16'h8200 >> i) & 16'h1) != 0);
        strobe(1'b0);
        check("par_bad_upd", sm_ir_update_hacr, 0);
        check("par_bad_err", sm_frame_err, 1);
        check("par_bad_cnt", upd_cnt - base, 0);
        send_hacr(16'h8200);
        check("par_ok_upd", sm_ir_update_hacr, 1);
        had_abort = 1'b1;
        tick();
        had_abort = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
